// File: rtl/cache_fill_arbiter.sv
// Miss-handling sequencer shared by the I-cache and the D-cache.
// It arbitrates write-through stores and line misses onto the single
// pipelined main memory, streams 8-word block fills into the requesting
// cache's data array, and writes the tag with the last word of the block.
module cache_fill_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I_Miss,
  input  logic [15:0] I_Miss_Addr,
  input  logic        D_Miss,
  input  logic [15:0] D_Miss_Addr,
  input  logic        D_Wr_Req,
  input  logic [15:0] D_Wr_Addr,
  input  logic [15:0] D_Wr_Data,
  output logic        D_Wr_Ack,
  output logic        Mem_Enable,
  output logic        Mem_Wr,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_Data_Out,
  input  logic        Mem_Data_Valid,
  input  logic [15:0] Mem_Data_In,
  output logic [15:0] Fill_Data,
  output logic [2:0]  Fill_Word_Num,
  output logic        I_Write_Data_Array,
  output logic        I_Write_Tag_Array,
  output logic        D_Write_Data_Array,
  output logic        D_Write_Tag_Array,
  output logic        I_Stall,
  output logic        D_Stall,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t      state, state_nxt;
  logic        grant_d;     // 1: current fill belongs to the D-cache
  logic [15:0] base;        // block base address of the current fill
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  issue_cnt;   // read requests issued in this fill
  logic [3:0]  recv_cnt;    // read words received in this fill
  logic        take_word;

  assign take_word = (state == FILL) && Mem_Data_Valid && !recv_cnt[3];

  // State register plus grant/address latches and fill counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_d   <= 1'b0;
      base      <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
          if (D_Wr_Req) begin
            wr_addr <= D_Wr_Addr;
            wr_data <= D_Wr_Data;
          end else if (D_Miss) begin
            grant_d <= 1'b1;
            base    <= D_Miss_Addr & 16'hFFF0;
          end else if (I_Miss) begin
            grant_d <= 1'b0;
            base    <= I_Miss_Addr & 16'hFFF0;
          end
        end
        FILL: begin
          if (!issue_cnt[3]) issue_cnt <= issue_cnt + 4'd1;
          if (take_word)     recv_cnt  <= recv_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state selection and all memory/cache/stall outputs.
  always_comb begin
    state_nxt          = state;
    D_Wr_Ack           = 1'b0;
    Mem_Enable         = 1'b0;
    Mem_Wr             = 1'b0;
    Mem_Addr           = '0;
    Mem_Data_Out       = '0;
    Fill_Data          = Mem_Data_In;
    Fill_Word_Num      = '0;
    I_Write_Data_Array = 1'b0;
    I_Write_Tag_Array  = 1'b0;
    D_Write_Data_Array = 1'b0;
    D_Write_Tag_Array  = 1'b0;
    Busy               = (state != IDLE);
    I_Stall            = I_Miss | (!grant_d && state == FILL);
    D_Stall            = D_Miss | D_Wr_Req | (grant_d && state == FILL);
    case (state)
      IDLE: begin
        if (D_Wr_Req)             state_nxt = WRITE;
        else if (D_Miss || I_Miss) state_nxt = FILL;
      end
      WRITE: begin
        Mem_Enable   = 1'b1;
        Mem_Wr       = 1'b1;
        Mem_Addr     = wr_addr;
        Mem_Data_Out = wr_data;
        D_Wr_Ack     = 1'b1;
        state_nxt    = IDLE;
      end
      FILL: begin
        if (!issue_cnt[3]) begin
          Mem_Enable = 1'b1;
          Mem_Addr   = base + {12'd0, issue_cnt[2:0], 1'b0};
        end
        if (take_word) begin
          Fill_Word_Num = recv_cnt[2:0];
          if (grant_d) D_Write_Data_Array = 1'b1;
          else         I_Write_Data_Array = 1'b1;
          // Tag goes in with the last word so a partial line never looks valid.
          if (recv_cnt[2:0] == 3'd7) begin
            if (grant_d) D_Write_Tag_Array = 1'b1;
            else         I_Write_Tag_Array = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a pipelined memory model and
// queues of expected memory requests and cache array writes.
module tb_cache_fill_arbiter;
  localparam int MEM_LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        I_Miss, D_Miss, D_Wr_Req;
  logic [15:0] I_Miss_Addr, D_Miss_Addr, D_Wr_Addr, D_Wr_Data;
  logic        D_Wr_Ack, Mem_Enable, Mem_Wr;
  logic [15:0] Mem_Addr, Mem_Data_Out, Mem_Data_In, Fill_Data;
  logic        Mem_Data_Valid;
  logic [2:0]  Fill_Word_Num;
  logic        I_Write_Data_Array, I_Write_Tag_Array;
  logic        D_Write_Data_Array, D_Write_Tag_Array;
  logic        I_Stall, D_Stall, Busy;

  cache_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .I_Miss(I_Miss), .I_Miss_Addr(I_Miss_Addr),
    .D_Miss(D_Miss), .D_Miss_Addr(D_Miss_Addr),
    .D_Wr_Req(D_Wr_Req), .D_Wr_Addr(D_Wr_Addr), .D_Wr_Data(D_Wr_Data),
    .D_Wr_Ack(D_Wr_Ack),
    .Mem_Enable(Mem_Enable), .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr),
    .Mem_Data_Out(Mem_Data_Out),
    .Mem_Data_Valid(Mem_Data_Valid), .Mem_Data_In(Mem_Data_In),
    .Fill_Data(Fill_Data), .Fill_Word_Num(Fill_Word_Num),
    .I_Write_Data_Array(I_Write_Data_Array), .I_Write_Tag_Array(I_Write_Tag_Array),
    .D_Write_Data_Array(D_Write_Data_Array), .D_Write_Tag_Array(D_Write_Tag_Array),
    .I_Stall(I_Stall), .D_Stall(D_Stall), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Pipelined memory: a read issued in cycle c returns in cycle c+MEM_LATENCY.
  // Returned word = data_ofs + (word index in block) + 1.
  logic [MEM_LATENCY-1:0] vpipe;
  logic [15:0]            apipe [MEM_LATENCY];
  logic                   stray;
  logic [15:0]            data_ofs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) apipe[i] <= '0;
    end else begin
      vpipe    <= {vpipe[MEM_LATENCY-2:0], Mem_Enable & ~Mem_Wr};
      apipe[0] <= Mem_Addr;
      for (int i = 1; i < MEM_LATENCY; i++) apipe[i] <= apipe[i-1];
    end
  end
  assign Mem_Data_Valid = vpipe[MEM_LATENCY-1] | stray;
  assign Mem_Data_In    = data_ofs + 16'(apipe[MEM_LATENCY-1][3:1]) + 16'd1;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } mreq_t;

  typedef struct {
    logic        d;
    logic        tag;
    logic [2:0]  word;
    logic [15:0] data;
    int          cyc;
  } fill_t;

  mreq_t mq[$];
  fill_t fq[$];

  int total = 0;
  int bad   = 0;
  int cnum  = 0;
  int t0;
  int i_lo = 1, i_hi = 0, d_lo = 1, d_hi = 0, w_cyc = -1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cnum);
    end
  endtask

  // Queue a fill granted in cycle g: reads in g+1.., words back MEM_LATENCY later.
  task automatic expect_fill(input logic d, input logic [15:0] base, input int g,
                             input int nissue, input int nrecv, input int last);
    for (int k = 0; k < nissue; k++)
      mq.push_back('{1'b0, base + 16'(2*k), 16'h0, g + 1 + k});
    for (int k = 0; k < nrecv; k++)
      fq.push_back('{d, k == 7, 3'(k), data_ofs + 16'(k + 1), g + 1 + k + MEM_LATENCY});
    if (d) begin d_lo = g + 1; d_hi = last; end
    else   begin i_lo = g + 1; i_hi = last; end
  endtask

  task automatic expect_store(input logic [15:0] a, input logic [15:0] dt, input int g);
    mq.push_back('{1'b1, a, dt, g + 1});
    w_cyc = g + 1;
  endtask

  // Check the current cycle against the expectations, then advance one clock.
  task automatic step();
    logic       ifill, dfill, busy_e;
    logic [3:0] st, st_e;
    mreq_t      m;
    fill_t      f;
    #1;
    ifill  = (cnum >= i_lo) && (cnum <= i_hi);
    dfill  = (cnum >= d_lo) && (cnum <= d_hi);
    busy_e = ifill | dfill | (cnum == w_cyc);
    chk("busy",    16'(Busy),    16'(busy_e));
    chk("i_stall", 16'(I_Stall), 16'(I_Miss | ifill));
    chk("d_stall", 16'(D_Stall), 16'(D_Miss | D_Wr_Req | dfill));
    if (!busy_e) begin
      chk("idle_addr",  Mem_Addr,             16'h0);
      chk("idle_wdata", Mem_Data_Out,         16'h0);
      chk("idle_word",  16'(Fill_Word_Num),   16'h0);
    end
    if (Mem_Enable) begin
      if (mq.size() == 0) chk("mem_unexp", 16'(Mem_Enable), 16'h0);
      else begin
        m = mq.pop_front();
        chk("mem_cyc",  16'(cnum),     16'(m.cyc));
        chk("mem_wr",   16'(Mem_Wr),   16'(m.wr));
        chk("mem_addr", Mem_Addr,      m.addr);
        chk("wr_ack",   16'(D_Wr_Ack), 16'(m.wr));
        if (m.wr) chk("mem_wdata", Mem_Data_Out, m.data);
      end
    end else begin
      chk("ack_idle", 16'(D_Wr_Ack), 16'h0);
    end
    st = {I_Write_Data_Array, I_Write_Tag_Array, D_Write_Data_Array, D_Write_Tag_Array};
    if (st != 4'b0) begin
      if (fq.size() == 0) chk("fill_unexp", 16'(st), 16'h0);
      else begin
        f = fq.pop_front();
        st_e = f.d ? {2'b00, 1'b1, f.tag} : {1'b1, f.tag, 2'b00};
        chk("fill_cyc",  16'(cnum),          16'(f.cyc));
        chk("strobes",   16'(st),            16'(st_e));
        chk("fill_word", 16'(Fill_Word_Num), 16'(f.word));
        chk("fill_data", Fill_Data,          f.data);
      end
    end
    @(posedge clk);
    #1;
    cnum++;
  endtask

  task automatic run_until(input int n);
    while (cnum < n) step();
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_mq_left"}, 16'(mq.size()), 16'h0);
    chk({tag, "_fq_left"}, 16'(fq.size()), 16'h0);
  endtask

  initial begin
    // Reset with every request asserted and a stray return pulse.
    rst_n = 1'b0; I_Miss = 1'b1; D_Miss = 1'b1; D_Wr_Req = 1'b1;
    I_Miss_Addr = 16'h0806; D_Miss_Addr = 16'h1234;
    D_Wr_Addr = 16'h00A2; D_Wr_Data = 16'hBEEF;
    stray = 1'b1; data_ofs = 16'h0;
    #2;
    chk("rst_mem_en", 16'(Mem_Enable), 16'h0);
    chk("rst_ack",    16'(D_Wr_Ack),   16'h0);
    chk("rst_busy",   16'(Busy),       16'h0);
    chk("rst_addr",   Mem_Addr,        16'h0);
    chk("rst_strb",   16'({I_Write_Data_Array, I_Write_Tag_Array,
                           D_Write_Data_Array, D_Write_Tag_Array}), 16'h0);
    step(); step();
    I_Miss = 1'b0; D_Miss = 1'b0; D_Wr_Req = 1'b0; stray = 1'b0; rst_n = 1'b1;
    step(); step();

    // Stray return in IDLE.
    stray = 1'b1; step(); stray = 1'b0; step();

    // I fill from 0x0806, data 1..8.
    data_ofs = 16'h0; t0 = cnum;
    I_Miss = 1'b1; I_Miss_Addr = 16'h0806;
    expect_fill(1'b0, 16'h0800, t0, 8, 8, t0 + 12);
    run_until(t0 + 13);
    I_Miss = 1'b0;
    // Ninth return after the completed fill.
    stray = 1'b1; step(); stray = 1'b0; step();
    chk_drained("ifill");

    // Contention: D miss wins, I fill follows in cycle 13.
    data_ofs = 16'h0100; t0 = cnum;
    I_Miss = 1'b1; I_Miss_Addr = 16'h0800;
    D_Miss = 1'b1; D_Miss_Addr = 16'h1234;
    expect_fill(1'b1, 16'h1230, t0, 8, 8, t0 + 12);
    expect_fill(1'b0, 16'h0800, t0 + 13, 8, 8, t0 + 25);
    run_until(t0 + 13);
    D_Miss = 1'b0;
    run_until(t0 + 26);
    I_Miss = 1'b0;
    step();
    chk_drained("contend");

    // Store beats a simultaneous I miss.
    data_ofs = 16'h0200; t0 = cnum;
    D_Wr_Req = 1'b1; D_Wr_Addr = 16'h00A2; D_Wr_Data = 16'hBEEF;
    I_Miss = 1'b1; I_Miss_Addr = 16'h0800;
    expect_store(16'h00A2, 16'hBEEF, t0);
    expect_fill(1'b0, 16'h0800, t0 + 2, 8, 8, t0 + 14);
    step(); step();
    D_Wr_Req = 1'b0;
    run_until(t0 + 15);
    I_Miss = 1'b0;
    step();
    chk_drained("store");

    // Reset in cycle 6 of an I fill, then restart from word 0.
    data_ofs = 16'h0300; t0 = cnum;
    I_Miss = 1'b1; I_Miss_Addr = 16'h034A;
    expect_fill(1'b0, 16'h0340, t0, 5, 1, t0 + 5);
    run_until(t0 + 6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_en", 16'(Mem_Enable),        16'h0);
    chk("mid_rst_addr",   Mem_Addr,               16'h0);
    chk("mid_rst_busy",   16'(Busy),              16'h0);
    chk("mid_rst_wda",    16'(I_Write_Data_Array), 16'h0);
    chk("mid_rst_wta",    16'(I_Write_Tag_Array),  16'h0);
    step(); step();
    rst_n = 1'b1;
    expect_fill(1'b0, 16'h0340, t0 + 8, 8, 8, t0 + 20);
    run_until(t0 + 21);
    I_Miss = 1'b0;
    step(); step();
    chk_drained("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
